pipe_hazard_ctrl: RTL and testbench

- Central hazard, stall and flush sequencer for the 5-stage MIPS pipeline with branch predictor.
- Drives the write-enable and flush inputs of the IF/ID and ID/EX pipeline registers and the PC mux.
- Detects load-use hazards, memory-busy stalls and branch mispredictions resolved in EX.
- Generates the recovery PC and a registered predictor-update record; keeps saturating branch and mispredict counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_if.sv | 55 +++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and branch predictor.
// Holds the sequencer state encoding and the predictor-update record.
package pipe_ctrl_pkg;

    localparam int DEF_PC_WIDTH       = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic                    valid;
        logic [DEF_PC_WIDTH-1:0] pc;
        logic                    taken;
    } bp_update_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_WIDTH       = DEF_PC_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 16
);
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic                      id_uses_rt;
    logic                      ex_mem_read;
    logic [REG_ADDR_WIDTH-1:0] ex_rt;
    logic                      mem_busy;
    logic                      br_valid;
    logic                      br_pred;
    logic                      br_taken;
    logic [PC_WIDTH-1:0]       br_target;
    logic [PC_WIDTH-1:0]       br_save_pc;
    logic [PC_WIDTH-1:0]       br_pc;

    logic                      pc_write;
    logic                      if_id_write;
    logic                      if_id_flush;
    logic                      id_ex_flush;
    logic                      redirect_valid;
    logic [PC_WIDTH-1:0]       redirect_pc;
    logic                      bp_upd_valid;
    logic [PC_WIDTH-1:0]       bp_upd_pc;
    logic                      bp_upd_taken;
    logic [CNT_WIDTH-1:0]      branch_count;
    logic [CNT_WIDTH-1:0]      mispredict_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
        output mem_busy, br_valid, br_pred, br_taken,
        output br_target, br_save_pc, br_pc,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush,
        input  redirect_valid, redirect_pc,
        input  bp_upd_valid, bp_upd_pc, bp_upd_taken,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
        input  mem_busy, br_valid, br_pred, br_taken,
        input  br_target, br_save_pc, br_pc,
        output pc_write, if_id_write, if_id_flush, id_ex_flush,
        output redirect_valid, redirect_pc,
        output bp_upd_valid, bp_upd_pc, bp_upd_taken,
        output branch_count, mispredict_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage pipeline: load-use,
// memory-busy and EX-resolved mispredict recovery, plus branch stats.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_WIDTH       = DEF_PC_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_WIDTH      = 16
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [2:0] FC_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI     = (FLUSH_CYCLES > 1);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                mispredict;
    logic                load_use;
    logic                rs_hit, rt_hit;

    logic                pc_write, if_id_write;
    logic                if_id_flush, id_ex_flush;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;

    logic                upd_valid_q, upd_taken_q;
    logic [PC_WIDTH-1:0] upd_pc_q;

    assign mispredict = bus.br_valid & (bus.br_taken != bus.br_pred);
    assign rs_hit     = (bus.ex_rt == bus.id_rs);
    assign rt_hit     = bus.id_uses_rt & (bus.ex_rt == bus.id_rt);
    assign load_use   = bus.ex_mem_read & (bus.ex_rt != '0)
                      & (rs_hit | rt_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A mispredict always (re)starts the flush window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mispredict) begin
            if (MULTI) begin
                state_d = FLUSH;
                cnt_d   = FC_RELOAD;
            end
        end else if ((state_q == FLUSH) && !bus.mem_busy) begin
            if (cnt_q <= 3'd1) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (mispredict) begin
            redirect_valid = 1'b1;
            redirect_pc    = bus.br_taken ? bus.br_target
                                          : bus.br_save_pc;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
        end else if (state_q == FLUSH) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_write    = ~bus.mem_busy;
            if_id_write = ~bus.mem_busy;
        end else if (bus.mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            upd_valid_q <= bus.br_valid;
            if (bus.br_valid) begin
                upd_pc_q    <= bus.br_pc;
                upd_taken_q <= bus.br_taken;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.br_valid),
        .count (bus.branch_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mp_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mispredict),
        .count (bus.mispredict_count)
    );

    assign bus.pc_write       = pc_write;
    assign bus.if_id_write    = if_id_write;
    assign bus.if_id_flush    = if_id_flush;
    assign bus.id_ex_flush    = id_ex_flush;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.bp_upd_valid   = upd_valid_q;
    assign bus.bp_upd_pc      = upd_pc_q;
    assign bus.bp_upd_taken   = upd_taken_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=3, CNT_WIDTH=4).
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int PCW = 32;
    localparam int RAW = 5;
    localparam int CW  = 4;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, redirect_valid}
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_BUSY  = 5'b00000;
    localparam logic [4:0] C_FL    = 5'b11110;
    localparam logic [4:0] C_FLB   = 5'b00110;
    localparam logic [4:0] C_MP    = 5'b11111;

    typedef struct packed {
        logic [RAW-1:0] id_rs;
        logic [RAW-1:0] id_rt;
        logic           uses_rt;
        logic           mem_read;
        logic [RAW-1:0] ex_rt;
        logic           mem_busy;
        logic           br_valid;
        logic           br_pred;
        logic           br_taken;
        logic [PCW-1:0] target;
        logic [PCW-1:0] save;
        logic [PCW-1:0] pc;
    } vec_t;

    typedef struct packed {
        logic [4:0]     c;
        logic [PCW-1:0] rpc;
        logic           bv;
        logic [PCW-1:0] bpc;
        logic           bt;
        logic [CW-1:0]  bc;
        logic [CW-1:0]  mc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   drv_done = 1'b0;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(
        .PC_WIDTH(PCW), .REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)
    ) bus ();

    pipe_hazard_ctrl #(
        .PC_WIDTH(PCW), .REG_ADDR_WIDTH(RAW),
        .FLUSH_CYCLES(3), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic vec_t idle();
        vec_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_t lu(input logic [RAW-1:0] rs,
                                input logic [RAW-1:0] rt,
                                input logic uses,
                                input logic [RAW-1:0] exrt);
        vec_t v;
        v = '0;
        v.id_rs    = rs;
        v.id_rt    = rt;
        v.uses_rt  = uses;
        v.mem_read = 1'b1;
        v.ex_rt    = exrt;
        return v;
    endfunction

    function automatic vec_t br(input logic pred, input logic tk,
                                input logic [PCW-1:0] tgt,
                                input logic [PCW-1:0] sv,
                                input logic [PCW-1:0] pc);
        vec_t v;
        v = '0;
        v.br_valid = 1'b1;
        v.br_pred  = pred;
        v.br_taken = tk;
        v.target   = tgt;
        v.save     = sv;
        v.pc       = pc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.id_rs       = v.id_rs;
        bus.id_rt       = v.id_rt;
        bus.id_uses_rt  = v.uses_rt;
        bus.ex_mem_read = v.mem_read;
        bus.ex_rt       = v.ex_rt;
        bus.mem_busy    = v.mem_busy;
        bus.br_valid    = v.br_valid;
        bus.br_pred     = v.br_pred;
        bus.br_taken    = v.br_taken;
        bus.br_target   = v.target;
        bus.br_save_pc  = v.save;
        bus.br_pc       = v.pc;
    endtask

    task automatic step(input string nm, input vec_t v,
                        input logic [4:0] c, input logic [PCW-1:0] rpc,
                        input logic bv, input logic [PCW-1:0] bpc,
                        input logic bt, input int bc, input int mc);
        exp_t e;
        @(negedge clk);
        apply(v);
        e.c   = c;
        e.rpc = rpc;
        e.bv  = bv;
        e.bpc = bpc;
        e.bt  = bt;
        e.bc  = CW'(bc);
        e.mc  = CW'(mc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares every cycle an expectation is pending.
    initial begin
        exp_t  e, g;
        string nm;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                g.c   = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                         bus.id_ex_flush, bus.redirect_valid};
                g.rpc = bus.redirect_pc;
                g.bv  = bus.bp_upd_valid;
                g.bpc = bus.bp_upd_pc;
                g.bt  = bus.bp_upd_taken;
                g.bc  = bus.branch_count;
                g.mc  = bus.mispredict_count;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s got c=%b rpc=%h bp=%b/%h/%b cnt=%0d/%0d exp c=%b rpc=%h bp=%b/%h/%b cnt=%0d/%0d",
                             nm, g.c, g.rpc, g.bv, g.bpc, g.bt, g.bc, g.mc,
                             e.c, e.rpc, e.bv, e.bpc, e.bt, e.bc, e.mc);
                end
            end
        end
    end

    initial begin
        vec_t v;
        reset = 1'b1;
        apply(idle());
        #12 reset = 1'b0;

        step("reset", idle(), C_RUN, 0, 0, 0, 0, 0, 0);
        step("load_use", lu(8, 0, 0, 8), C_STALL, 0, 0, 0, 0, 0, 0);
        step("after_lu", idle(), C_RUN, 0, 0, 0, 0, 0, 0);
        step("lu_rt0", lu(0, 0, 0, 0), C_RUN, 0, 0, 0, 0, 0, 0);
        step("lu_rt", lu(3, 9, 1, 9), C_STALL, 0, 0, 0, 0, 0, 0);
        step("rt_unused", lu(3, 9, 0, 9), C_RUN, 0, 0, 0, 0, 0, 0);
        v = idle();
        v.mem_busy = 1'b1;
        step("mem_busy", v, C_BUSY, 0, 0, 0, 0, 0, 0);

        step("mp_taken", br(0, 1, 32'h40, 32'h14, 32'h10),
             C_MP, 32'h40, 0, 0, 0, 0, 0);
        step("mp_t_fl1", idle(), C_FL, 0, 1, 32'h10, 1, 1, 1);
        step("mp_t_fl2", idle(), C_FL, 0, 0, 32'h10, 1, 1, 1);
        step("mp_t_run", idle(), C_RUN, 0, 0, 32'h10, 1, 1, 1);

        step("mp_nt", br(1, 0, 32'h80, 32'h24, 32'h20),
             C_MP, 32'h24, 0, 32'h10, 1, 1, 1);
        step("nt_fl1", idle(), C_FL, 0, 1, 32'h20, 0, 2, 2);
        step("nt_fl2", idle(), C_FL, 0, 0, 32'h20, 0, 2, 2);
        step("nt_run", idle(), C_RUN, 0, 0, 32'h20, 0, 2, 2);

        step("mp_busy", br(0, 1, 32'h100, 32'h104, 32'hFC),
             C_MP, 32'h100, 0, 32'h20, 0, 2, 2);
        v = idle();
        v.mem_busy = 1'b1;
        step("fl_busy", v, C_FLB, 0, 1, 32'hFC, 1, 3, 3);
        step("fl_frz1", idle(), C_FL, 0, 0, 32'hFC, 1, 3, 3);
        step("fl_frz2", idle(), C_FL, 0, 0, 32'hFC, 1, 3, 3);
        step("frz_run", idle(), C_RUN, 0, 0, 32'hFC, 1, 3, 3);

        v = br(0, 1, 32'h200, 32'h204, 32'h1FC);
        v.mem_read = 1'b1;
        v.ex_rt    = 5'd8;
        v.id_rs    = 5'd8;
        v.mem_busy = 1'b1;
        step("simul", v, C_MP, 32'h200, 0, 32'hFC, 1, 3, 3);
        step("fl_lu", lu(8, 0, 0, 8), C_FL, 0, 1, 32'h1FC, 1, 4, 4);
        step("mp_in_fl", br(1, 0, 32'h400, 32'h300, 32'h2FC),
             C_MP, 32'h300, 0, 32'h1FC, 1, 4, 4);
        step("refl1", idle(), C_FL, 0, 1, 32'h2FC, 0, 5, 5);
        step("refl2", idle(), C_FL, 0, 0, 32'h2FC, 0, 5, 5);
        step("refl_run", idle(), C_RUN, 0, 0, 32'h2FC, 0, 5, 5);

        step("correct", br(1, 1, 32'h500, 32'h504, 32'h4FC),
             C_RUN, 0, 0, 32'h2FC, 0, 5, 5);
        step("correct_upd", idle(), C_RUN, 0, 1, 32'h4FC, 1, 6, 5);

        for (int i = 0; i < 20; i++) begin
            step("sat_mp", br(0, 1, 32'h600, 32'h604, 32'h5FC),
                 C_MP, 32'h600, (i > 0),
                 (i > 0) ? 32'h5FC : 32'h4FC, 1,
                 (6 + i > 15) ? 15 : 6 + i,
                 (5 + i > 15) ? 15 : 5 + i);
        end
        step("sat_fl1", idle(), C_FL, 0, 1, 32'h5FC, 1, 15, 15);
        step("sat_fl2", idle(), C_FL, 0, 0, 32'h5FC, 1, 15, 15);
        step("sat_run", idle(), C_RUN, 0, 0, 32'h5FC, 1, 15, 15);

        step("rst_mp", br(0, 1, 32'h700, 32'h704, 32'h6FC),
             C_MP, 32'h700, 0, 32'h5FC, 1, 15, 15);
        step("rst_fl1", idle(), C_FL, 0, 1, 32'h6FC, 1, 15, 15);
        @(posedge clk);
        #2 reset = 1'b1;
        step("rst_async", idle(), C_RUN, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        step("post_rst", idle(), C_RUN, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        drv_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
